// File: rtl/eg4_tty_tx_pkg.sv
// Shared constants and types for the debug TTY serialiser.
// Holds the default baud/FIFO configuration and the transmitter state type.
package eg4_tty_tx_pkg;

  localparam int unsigned CONFIG_DBG_BAUD     = 115200;
  localparam int unsigned CONFIG_DBG_FIFO_LOG = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // Clocks per serial bit, truncated.
  function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/eg4_tty_tx_if.sv
// Debug byte stream from the CPU wrapper plus the serialiser's status outputs.
// The master side is the producer of tty_*; the slave side is the serialiser.
interface eg4_tty_tx_if;
  logic       tty_stb;
  logic [7:0] tty_dat;
  logic       tty_end;
  logic       txd;
  logic       busy;
  logic       ovf;
  logic       done;

  modport master (
    output tty_stb, tty_dat, tty_end,
    input  txd, busy, ovf, done
  );

  modport slave (
    input  tty_stb, tty_dat, tty_end,
    output txd, busy, ovf, done
  );
endinterface

// File: rtl/eg4_tty_tx_fifo.sv
// Circular byte FIFO with naturally wrapping pointers and an explicit level count.
// A push is honoured when there is room or when a pop frees a slot in the same cycle.
module eg4_tty_tx_fifo #(
  parameter int unsigned LOG = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [7:0]   din,
  input  logic         pop,
  output logic [7:0]   dout,
  output logic         full,
  output logic         empty,
  output logic [LOG:0] count
);
  localparam int unsigned  DEPTH = 1 << LOG;
  localparam logic [LOG-1:0] PTR_ONE = LOG'(1);
  localparam logic [LOG:0]   CNT_ONE = (LOG+1)'(1);

  logic [7:0]     mem [DEPTH];
  logic [LOG-1:0] wr_ptr;
  logic [LOG-1:0] rd_ptr;
  logic           do_pop;
  logic           do_push;

  assign empty   = (count == '0);
  assign full    = count[LOG];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/eg4_tty_tx.sv
// Debug TTY serialiser: buffers tty_* bytes in a FIFO and sends them as 8N1 frames on txd.
// One IDLE cycle separates back-to-back frames, so the frame period is 10*DIV+1 clocks.
module eg4_tty_tx
  import eg4_tty_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned BAUD     = CONFIG_DBG_BAUD,
  parameter int unsigned FIFO_LOG = CONFIG_DBG_FIFO_LOG
) (
  input logic         wb_clk_i,
  input logic         wb_rst_i,
  eg4_tty_tx_if.slave tty
);
  localparam int unsigned DIV = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned CW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          txd_r;
  logic          busy_r;
  logic          ovf_r;
  logic          done_r;
  logic          end_seen;

  logic [7:0]        head;
  logic              full;
  logic              empty;
  logic [FIFO_LOG:0] level;
  logic [FIFO_LOG:0] level_nx;
  logic              pop;
  logic              accept;
  logic              drop;
  logic              leaving_stop;
  logic              active_nx;

  assign pop    = (state == ST_IDLE) & ~empty;
  assign accept = tty.tty_stb & ~end_seen & (~full | pop);
  assign drop   = tty.tty_stb & ~end_seen & ~accept;

  // busy is registered alongside the FSM, so it is derived from next-cycle level and state.
  assign level_nx     = level + {{FIFO_LOG{1'b0}}, accept} - {{FIFO_LOG{1'b0}}, pop};
  assign leaving_stop = (state == ST_STOP) & (baud_cnt == '0);
  assign active_nx    = pop | ((state != ST_IDLE) & ~leaving_stop);

  eg4_tty_tx_fifo #(.LOG(FIFO_LOG)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (accept),
    .din   (tty.tty_dat),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (level)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      txd_r    <= 1'b1;
      busy_r   <= 1'b0;
      ovf_r    <= 1'b0;
      done_r   <= 1'b0;
      end_seen <= 1'b0;
    end else begin
      if (drop)        ovf_r    <= 1'b1;
      if (tty.tty_end) end_seen <= 1'b1;
      busy_r <= (level_nx != '0) | active_nx;
      done_r <= end_seen & ~busy_r;

      case (state)
        ST_IDLE: begin
          txd_r <= 1'b1;
          if (pop) begin
            shreg    <= head;
            baud_cnt <= DIV_M1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          txd_r <= 1'b0;
          if (baud_cnt == '0) begin
            baud_cnt <= DIV_M1;
            bit_idx  <= '0;
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end
        ST_DATA: begin
          txd_r <= shreg[0];
          if (baud_cnt == '0) begin
            baud_cnt <= DIV_M1;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) state <= ST_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end
        ST_STOP: begin
          txd_r <= 1'b1;
          if (baud_cnt == '0) state <= ST_IDLE;
          else                baud_cnt <= baud_cnt - CNT_ONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign tty.txd  = txd_r;
  assign tty.busy = busy_r;
  assign tty.ovf  = ovf_r;
  assign tty.done = done_r;

endmodule
